sig_mmio_ctrl: RTL and testbench

// Synthesizable controller for the tiny-SoC signature MMIO window. It snoops the core data-memory

---
 rtl/sig_mmio_ctrl.sv | 109 ++++++++++
 tb/tb_sig_mmio_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_mmio_ctrl.sv
// sig_mmio_ctrl: signature MMIO decode, register-dump FIFO and stop/SIMLEN run sequencing.
// Optional macro SIG_TRAP_STOP_EN makes a trap-signature write end the run like a stop write.
module sig_mmio_ctrl #(
    parameter logic [63:0] ADDR_STOP  = 64'h0,
    parameter logic [63:0] ADDR_TRAP  = 64'h8,
    parameter logic [63:0] ADDR_IREG  = 64'h10,
    parameter logic [63:0] ADDR_FREG  = 64'h18,
    parameter int          STOP_DELAY = 50,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_req_i,
    input  logic             mem_we_i,
    input  logic [63:0]      mem_addr_i,
    input  logic [63:0]      mem_wdata_i,
    input  logic [CNT_W-1:0] simlen_i,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic             dump_is_fp_o,
    output logic [4:0]       dump_idx_o,
    output logic [63:0]      dump_data_o,
    output logic             overflow_o,
    output logic             done_o,
    output logic [1:0]       cause_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SIG_TRAP_STOP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {RUN, STOPPING, DRAIN, DONE} state_t;

    state_t        state;
    logic [31:0]   stop_cnt;
    logic [4:0]    int_idx, fp_idx;
    logic [69:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          wr, run, stop_hit, trap_hit, ireg_hit, freg_hit, push, pop, full, push_ok, sim_exp;

    assign wr       = mem_req_i & mem_we_i;
    assign run      = state == RUN;
    assign stop_hit = run & wr & (mem_addr_i == ADDR_STOP);
    assign trap_hit = TRAP_EN & run & wr & (mem_addr_i == ADDR_TRAP);
    assign ireg_hit = run & wr & (mem_addr_i == ADDR_IREG);
    assign freg_hit = run & wr & (mem_addr_i == ADDR_FREG);
    assign push     = ireg_hit | freg_hit;
    assign full     = count == (AW+1)'(FIFO_DEPTH);
    assign dump_valid_o = count != '0;
    assign pop      = dump_valid_o & dump_ready_i;
    assign push_ok  = push & (~full | pop);
    assign sim_exp  = (simlen_i != '0) && (cycle_cnt_o == simlen_i - CNT_W'(1));
    // Head fields read as zero while the FIFO is empty so reset leaves every output at 0.
    assign {dump_is_fp_o, dump_idx_o, dump_data_o} = dump_valid_o ? mem[rd_ptr] : 70'd0;

    always_ff @(posedge clk_i)
        if (push_ok) mem[wr_ptr] <= {freg_hit, freg_hit ? fp_idx : int_idx, mem_wdata_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= RUN;
            stop_cnt    <= 32'(STOP_DELAY);
            int_idx     <= 5'd1;
            fp_idx      <= 5'd0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            overflow_o  <= 1'b0;
            done_o      <= 1'b0;
            cause_o     <= 2'd0;
            cycle_cnt_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (push & ~push_ok) overflow_o <= 1'b1;
            // Indices advance on every accepted-by-decode dump, dropped or not.
            if (ireg_hit) int_idx <= (int_idx == 5'd31) ? 5'd1 : int_idx + 5'd1;
            if (freg_hit) fp_idx <= fp_idx + 5'd1;
            case (state)
                RUN:
                    if (stop_hit | trap_hit) begin
                        state   <= STOPPING;
                        cause_o <= trap_hit ? 2'd3 : 2'd1;
                    end else if (sim_exp) begin
                        state   <= DRAIN;
                        cause_o <= 2'd2;
                    end else begin
                        cycle_cnt_o <= cycle_cnt_o + CNT_W'(~&cycle_cnt_o);
                    end
                STOPPING: begin
                    stop_cnt <= stop_cnt - 32'd1;
                    if (stop_cnt <= 32'd1) state <= DRAIN;
                end
                DRAIN:
                    if (!dump_valid_o) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                default: state <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_sig_mmio_ctrl.sv
// tb_sig_mmio_ctrl: vector table, directed run-control sequences and a queue-based random model.
module tb_sig_mmio_ctrl;
    localparam logic [63:0] A_STOP = 64'h0, A_TRAP = 64'h8, A_IREG = 64'h10, A_FREG = 64'h18;
    localparam int DEPTH = 8, DELAY = 50, CW = 32;
`ifdef SIG_TRAP_STOP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk_i = 1'b0, rst_i = 1'b0;
    logic mem_req_i = 1'b0, mem_we_i = 1'b0, dump_ready_i = 1'b0;
    logic [63:0] mem_addr_i = '0, mem_wdata_i = '0;
    logic [CW-1:0] simlen_i = '0;
    logic dump_valid_o, dump_is_fp_o, overflow_o, done_o;
    logic [4:0] dump_idx_o;
    logic [63:0] dump_data_o;
    logic [1:0] cause_o;
    logic [CW-1:0] cycle_cnt_o;

    sig_mmio_ctrl #(
        .ADDR_STOP(A_STOP), .ADDR_TRAP(A_TRAP), .ADDR_IREG(A_IREG), .ADDR_FREG(A_FREG),
        .STOP_DELAY(DELAY), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .simlen_i(simlen_i),
        .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i), .dump_is_fp_o(dump_is_fp_o),
        .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o), .overflow_o(overflow_o),
        .done_o(done_o), .cause_o(cause_o), .cycle_cnt_o(cycle_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;

    typedef struct {
        string       name;
        logic        req, we;
        logic [63:0] addr, data;
        logic        exp_valid, exp_fp;
        logic [4:0]  exp_idx;
        logic [1:0]  exp_cause;
    } vec_t;
    vec_t tbl[8];

    typedef struct {
        bit          fp;
        int          idx;
        logic [63:0] d;
    } ent_t;
    ent_t q[$];
    int m_phase, m_left, m_iidx, m_fidx, m_cause;
    bit m_ovf, m_done;
    longint m_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0;
    endtask

    task automatic write(input logic [63:0] a, input logic [63:0] d);
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = a; mem_wdata_i = d;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, dump_valid_o, 0);
        check({tag, "_isfp"}, dump_is_fp_o, 0);
        check({tag, "_idx"}, dump_idx_o, 0);
        check({tag, "_data"}, dump_data_o, 0);
        check({tag, "_ovf"}, overflow_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_cause"}, cause_o, 0);
        check({tag, "_cnt"}, cycle_cnt_o, 0);
    endtask

    task automatic do_reset();
        idle();
        dump_ready_i = 0;
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
    endtask

    // Reference model: advances one clock edge using the inputs currently driven.
    task automatic model_step();
        int sz;
        bit w;
        sz = q.size();
        w = mem_req_i && mem_we_i;
        if (sz > 0 && dump_ready_i) void'(q.pop_front());
        if (m_phase == 0 && w && (mem_addr_i == A_IREG || mem_addr_i == A_FREG)) begin
            ent_t e;
            e.fp = mem_addr_i == A_FREG;
            e.idx = e.fp ? m_fidx : m_iidx;
            e.d = mem_wdata_i;
            if (q.size() < DEPTH) q.push_back(e);
            else m_ovf = 1;
            if (e.fp) m_fidx = (m_fidx + 1) % 32;
            else m_iidx = m_iidx % 31 + 1;
        end
        if (m_phase == 0) begin
            if (w && (mem_addr_i == A_STOP || (TRAP_EN && mem_addr_i == A_TRAP))) begin
                m_phase = 1; m_left = DELAY; m_cause = (mem_addr_i == A_STOP) ? 1 : 3;
            end else if (simlen_i != 0 && m_cyc == longint'(simlen_i) - 1) begin
                m_phase = 2; m_cause = 2;
            end else if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left <= 0) m_phase = 2;
        end else if (m_phase == 2 && sz == 0) begin
            m_phase = 3; m_done = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [CW-1:0] c0;

        tbl[0] = '{"ireg",  1, 1, A_IREG, 64'h1111, 1, 0, 5'd1, 2'd0};
        tbl[1] = '{"freg",  1, 1, A_FREG, 64'h2222, 1, 1, 5'd0, 2'd0};
        tbl[2] = '{"noreq", 0, 1, A_IREG, 64'h3333, 0, 0, 5'd0, 2'd0};
        tbl[3] = '{"read",  1, 0, A_FREG, 64'h4444, 0, 0, 5'd0, 2'd0};
        tbl[4] = '{"miss",  1, 1, 64'h11, 64'h5555, 0, 0, 5'd0, 2'd0};
        tbl[5] = '{"hibit", 1, 1, 64'h1_0000_0010, 64'h6666, 0, 0, 5'd0, 2'd0};
        tbl[6] = '{"stop",  1, 1, A_STOP, 64'h7777, 0, 0, 5'd0, 2'd1};
        tbl[7] = '{"trap",  1, 1, A_TRAP, 64'h8888, 0, 0, 5'd0, TRAP_EN ? 2'd3 : 2'd0};

        rst_i = 1;
        #3;
        check_zero("rst");
        do_reset();

        foreach (tbl[k]) begin
            do_reset();
            mem_req_i = tbl[k].req; mem_we_i = tbl[k].we;
            mem_addr_i = tbl[k].addr; mem_wdata_i = tbl[k].data;
            tick();
            idle();
            check({tbl[k].name, "_valid"}, dump_valid_o, tbl[k].exp_valid);
            check({tbl[k].name, "_isfp"}, dump_is_fp_o, tbl[k].exp_fp);
            check({tbl[k].name, "_idx"}, dump_idx_o, tbl[k].exp_idx);
            check({tbl[k].name, "_data"}, dump_data_o, tbl[k].exp_valid ? tbl[k].data : 64'd0);
            check({tbl[k].name, "_cause"}, cause_o, tbl[k].exp_cause);
        end

        do_reset();
        dump_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            write(A_IREG, 64'hA + 64'(i));
            tick();
            check($sformatf("seq_valid%0d", i), dump_valid_o, 1);
            check($sformatf("seq_idx%0d", i), dump_idx_o, 5'(i + 1));
            check($sformatf("seq_data%0d", i), dump_data_o, 64'hA + 64'(i));
        end
        idle();
        tick();
        check("seq_empty", dump_valid_o, 0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            write(A_FREG, 64'hF00 + 64'(i));
            tick();
            if (i == 7) check("ovf_at_full", overflow_o, 0);
        end
        idle();
        check("ovf_set", overflow_o, 1);
        dump_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_idx%0d", i), dump_idx_o, 5'(i));
            check($sformatf("ovf_data%0d", i), dump_data_o, 64'hF00 + 64'(i));
            check($sformatf("ovf_fp%0d", i), dump_is_fp_o, 1);
            tick();
        end
        check("ovf_drained", dump_valid_o, 0);
        write(A_FREG, 64'h99);
        tick();
        idle();
        check("ovf_next_idx", dump_idx_o, 5'd9);
        check("ovf_sticky", overflow_o, 1);

        do_reset();
        repeat (100) tick();
        write(A_STOP, 64'h0);
        tick();
        check("stop_cause", cause_o, 1);
        c0 = cycle_cnt_o;
        write(A_IREG, 64'h55);
        tick();
        idle();
        n = 1;
        while (!done_o && n < 200) begin
            tick();
            n++;
        end
        check("stop_latency", n, DELAY + 1);
        check("stop_done", done_o, 1);
        check("stop_no_dump", dump_valid_o, 0);
        check("stop_cnt_frozen", cycle_cnt_o, c0);

        simlen_i = 20;
        do_reset();
        repeat (19) tick();
        check("sim_cnt19", cycle_cnt_o, 19);
        check("sim_cause_pre", cause_o, 0);
        tick();
        check("sim_cause", cause_o, 2);
        check("sim_cnt_hold", cycle_cnt_o, 19);
        check("sim_done_pre", done_o, 0);
        tick();
        check("sim_done", done_o, 1);
        check("sim_cnt_final", cycle_cnt_o, 19);
        simlen_i = 0;

        do_reset();
        write(A_TRAP, 64'h0);
        tick();
        idle();
        check("trap_cause", cause_o, TRAP_EN ? 2'd3 : 2'd0);
        repeat (60) tick();
        check("trap_done", done_o, TRAP_EN);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            write(A_IREG, 64'hD0 + 64'(i));
            tick();
        end
        write(A_STOP, 64'h0);
        tick();
        idle();
        repeat (DELAY + 1) tick();
        check("drain_valid", dump_valid_o, 1);
        check("drain_done", done_o, 0);
        #2 rst_i = 1;
        #1;
        check_zero("arst");
        tick();
        rst_i = 0;
        write(A_IREG, 64'hEE);
        tick();
        idle();
        check("arst_idx", dump_idx_o, 5'd1);
        check("arst_data", dump_data_o, 64'hEE);
        check("arst_ovf", overflow_o, 0);

        simlen_i = $urandom_range(0, 1) ? CW'($urandom_range(300, 500)) : '0;
        do_reset();
        q.delete();
        m_phase = 0; m_left = 0; m_iidx = 1; m_fidx = 0; m_cause = 0;
        m_ovf = 0; m_done = 0; m_cyc = 0;
        for (int i = 0; i < 700; i++) begin
            int r;
            r = $urandom_range(0, 99);
            mem_req_i = $urandom_range(0, 3) != 0;
            mem_we_i = $urandom_range(0, 3) != 0;
            mem_wdata_i = {$urandom, $urandom};
            mem_addr_i = r < 40 ? A_IREG : r < 70 ? A_FREG :
                         (i > 250 && r == 70) ? A_STOP : (i > 250 && r == 71) ? A_TRAP :
                         {$urandom, $urandom};
            dump_ready_i = $urandom_range(0, 9) < 4;
            model_step();
            tick();
            check("rnd_valid", dump_valid_o, q.size() > 0);
            check("rnd_isfp", dump_is_fp_o, q.size() > 0 ? q[0].fp : 1'b0);
            check("rnd_idx", dump_idx_o, q.size() > 0 ? 5'(q[0].idx) : 5'd0);
            check("rnd_data", dump_data_o, q.size() > 0 ? q[0].d : 64'd0);
            check("rnd_ovf", overflow_o, m_ovf);
            check("rnd_done", done_o, m_done);
            check("rnd_cause", cause_o, 2'(m_cause));
            check("rnd_cnt", cycle_cnt_o, CW'(m_cyc));
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
